// File: rtl/voltage_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module   : voltage_bcd_converter
// Purpose  : Sequential 12-bit binary to 4-digit packed BCD (double dabble),
//            one bit per clock under a start/busy/done handshake.
// Revision : 1.0  initial release
// ============================================================================
module voltage_bcd_converter #(
    parameter int WIDTH  = 12,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [WIDTH-1:0]      in_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_o
);

    localparam int                BCD_W  = 4 * DIGITS;
    localparam int                CNT_W  = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(WIDTH - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] bin_q,   bin_d;
    logic [BCD_W-1:0] scr_q,   scr_d;
    logic [BCD_W-1:0] bcd_q,   bcd_d;
    logic             done_q,  done_d;

    logic [BCD_W-1:0] corr;
    logic [BCD_W-1:0] shifted;

    // Add-3 correction on every nibble in parallel, before the shift
    for (genvar i = 0; i < DIGITS; i++) begin : g_nib
        assign corr[4*i +: 4] = (scr_q[4*i +: 4] >= 4'd5) ? (scr_q[4*i +: 4] + 4'd3)
                                                          :  scr_q[4*i +: 4];
    end

    assign shifted = {corr[BCD_W-2:0], bin_q[WIDTH-1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            scr_q   <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_SHIFT;
                    bin_d   = in_i;
                    scr_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_SHIFT: begin
                scr_d = shifted;
                bin_d = {bin_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == C_LAST) begin
                    state_d = S_IDLE;
                    bcd_d   = shifted;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q == S_SHIFT);
        done_o = done_q;
        bcd_o  = bcd_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_voltage_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module   : tb_voltage_bcd_converter
// Purpose  : Directed, table-driven self-checking bench for voltage_bcd_converter.
// Revision : 1.0  initial release
// ============================================================================
module tb_voltage_bcd_converter;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [11:0] in_i;
    logic        busy_o;
    logic        done_o;
    logic [15:0] bcd_o;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic [11:0] din;
        logic [15:0] exp_bcd;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    voltage_bcd_converter #(.WIDTH(12), .DIGITS(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .in_i    (in_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .bcd_o   (bcd_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Inputs change #1 after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle start; checks busy/done every cycle and the result at E12.
    task automatic run_conv(input logic [11:0] v, input logic [15:0] exp);
        start_i = 1'b1;
        in_i    = v;
        tick();
        start_i = 1'b0;
        in_i    = ~v;
        chk("busy_after_accept", 16'(busy_o), 16'd1);
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k < 12) begin
                chk("busy_mid", 16'(busy_o), 16'd1);
                chk("done_mid", 16'(done_o), 16'd0);
            end else begin
                chk("done_at_e12", 16'(done_o), 16'd1);
                chk("busy_at_e12", 16'(busy_o), 16'd0);
                chk("bcd_result",  bcd_o, exp);
            end
        end
        tick();
        chk("done_one_cycle", 16'(done_o), 16'd0);
        chk("bcd_holds",      bcd_o, exp);
    endtask

    initial begin
        int ndone;

        vecs[0] = '{din: 12'd3325, exp_bcd: 16'h3325};
        vecs[1] = '{din: 12'd0,    exp_bcd: 16'h0000};
        vecs[2] = '{din: 12'd4095, exp_bcd: 16'h4095};
        vecs[3] = '{din: 12'd1000, exp_bcd: 16'h1000};
        vecs[4] = '{din: 12'd1234, exp_bcd: 16'h1234};
        vecs[5] = '{din: 12'd9,    exp_bcd: 16'h0009};
        vecs[6] = '{din: 12'd999,  exp_bcd: 16'h0999};
        vecs[7] = '{din: 12'd1,    exp_bcd: 16'h0001};
        vecs[8] = '{din: 12'd2558, exp_bcd: 16'h2558};
        vecs[9] = '{din: 12'd3070, exp_bcd: 16'h3070};

        rst     = 1'b1;
        start_i = 1'b0;
        in_i    = '0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_busy", 16'(busy_o), 16'd0);
            chk("rst_done", 16'(done_o), 16'd0);
            chk("rst_bcd",  bcd_o, 16'h0000);
        end

        for (int i = 0; i < NVEC; i++) run_conv(vecs[i].din, vecs[i].exp_bcd);

        // Second start on the 5th busy cycle must be ignored
        start_i = 1'b1;
        in_i    = 12'd812;
        tick();
        start_i = 1'b0;
        ndone   = 0;
        for (int k = 1; k <= 14; k++) begin
            if (k == 5) begin
                start_i = 1'b1;
                in_i    = 12'd9;
            end else begin
                start_i = 1'b0;
            end
            tick();
            if (done_o) ndone++;
            if (k == 12) begin
                chk("ign_done_e12", 16'(done_o), 16'd1);
                chk("ign_bcd",      bcd_o, 16'h0812);
            end
        end
        chk("ign_done_count", 16'(ndone), 16'd1);
        chk("ign_idle", 16'(busy_o), 16'd0);

        // start held high: back-to-back conversions every 13 clocks
        start_i = 1'b1;
        in_i    = 12'd1234;
        tick();
        for (int k = 1; k <= 38; k++) begin
            tick();
            if (k == 38) start_i = 1'b0;
            chk("b2b_done", 16'(done_o), (k % 13 == 12) ? 16'd1 : 16'd0);
            chk("b2b_busy", 16'(busy_o), (k % 13 == 12) ? 16'd0 : 16'd1);
            if (k % 13 == 12) chk("b2b_bcd", bcd_o, 16'h1234);
        end
        tick();
        chk("b2b_stop_busy", 16'(busy_o), 16'd0);

        // Reset on the 6th busy cycle aborts with no done pulse
        start_i = 1'b1;
        in_i    = 12'd2047;
        tick();
        start_i = 1'b0;
        for (int k = 1; k <= 5; k++) tick();
        chk("abort_busy_before", 16'(busy_o), 16'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 16'(busy_o), 16'd0);
        chk("abort_done", 16'(done_o), 16'd0);
        chk("abort_bcd",  bcd_o, 16'h0000);
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done_o) ndone++;
        end
        chk("abort_no_done", 16'(ndone), 16'd0);
        chk("abort_bcd_hold", bcd_o, 16'h0000);
        run_conv(12'd2047, 16'h2047);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
